fb_pixel_serializer: RTL and testbench

FB_PIXEL_SERIALIZER -- requirements
Module: fb_pixel_serializer

---
 rtl/fb_pixel_serializer_if.sv | 9 +
 rtl/fb_pixel_serializer.sv | 137 +++++++++++++
 tb/tb_fb_pixel_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pixel_serializer_if.sv
// Framebuffer byte stream into the pixel serializer: DIN with valid/ready handshake.
interface fb_pixel_serializer_if;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;

  modport master (output DIN, output DIN_VALID, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/fb_pixel_serializer.sv
// Pixel-pair serializer: buffers framebuffer bytes in a small FIFO and emits one
// 4-bit pixel per cycle with palette bank, transparency/priority flags and clear-after-scan.
module fb_pixel_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  TRANSP_NIB = 4'h0,
  parameter logic [3:0]  BEHIND_NIB = 4'h7
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        BLK,
  input  logic                        nPL,
  fb_pixel_serializer_if.slave        din_if,
  input  logic                        S,
  input  logic                        XF,
  input  logic [4:0]                  PAL,
  input  logic                        CLR_EN,
  output logic [8:0]                  PIX,
  output logic                        PIX_VALID,
  output logic                        PIX_OPAQUE,
  output logic                        PIX_BEHIND,
  output logic                        WB_WE,
  output logic                        UNDERRUN
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            phase;
  logic [4:0]      pal_lat;
  logic [7:0]      byte_lat;
  logic            swap_lat;
  logic            under_lat;

  logic            ready, flush, emit1, emit2, pop, push;
  logic            out_valid, out_real;
  logic [7:0]      head;
  logic [3:0]      first_nib, second_nib, out_nib;

  assign ready            = (count < CW'(FIFO_DEPTH));
  assign din_if.DIN_READY = ready;

  always_comb begin
    state_d = state;
    flush   = 1'b0;
    emit1   = 1'b0;
    emit2   = 1'b0;
    if (!nPL) begin
      flush   = 1'b1;
      state_d = PRIME;
    end else begin
      case (state)
        IDLE:  state_d = IDLE;
        PRIME: if (BLK && (count >= CW'(2))) state_d = RUN;
        RUN: begin
          if (!phase) begin
            if (BLK) emit1 = 1'b1;
            else     state_d = IDLE;
          end else begin
            emit2 = 1'b1;
            if (!BLK) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pop  = emit1 && (count != '0);
    // A full FIFO still accepts a byte in the same cycle a pop frees a slot.
    push = din_if.DIN_VALID && (ready || pop) && !flush;

    head       = mem[rd_ptr];
    first_nib  = (S ^ XF) ? head[3:0] : head[7:4];
    second_nib = swap_lat ? byte_lat[7:4] : byte_lat[3:0];
    out_nib    = emit1 ? first_nib : second_nib;
    out_valid  = emit1 || emit2;
    out_real   = pop || (emit2 && !under_lat);
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= din_if.DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      phase      <= 1'b0;
      pal_lat    <= '0;
      byte_lat   <= '0;
      swap_lat   <= 1'b0;
      under_lat  <= 1'b0;
      PIX        <= '0;
      PIX_VALID  <= 1'b0;
      PIX_OPAQUE <= 1'b0;
      PIX_BEHIND <= 1'b0;
      WB_WE      <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      state <= state_d;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        phase   <= 1'b0;
        pal_lat <= PAL;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (emit1)      phase <= 1'b1;
        else if (emit2) phase <= 1'b0;
      end

      if (emit1) begin
        under_lat <= !pop;
        swap_lat  <= S ^ XF;
        if (pop) byte_lat <= head;
      end

      PIX        <= out_real ? {pal_lat, out_nib} : '0;
      PIX_VALID  <= out_valid;
      PIX_OPAQUE <= out_real && (out_nib != TRANSP_NIB);
      PIX_BEHIND <= out_real && (out_nib == BEHIND_NIB);
      WB_WE      <= pop && CLR_EN;
      if (emit1 && !pop) UNDERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_pixel_serializer.sv
// Directed bench for fb_pixel_serializer: per-cycle vector table plus hand sequences
// for FIFO-full, underrun, clear-after-scan, preload flush and mid-run reset.
module tb_fb_pixel_serializer;

  logic       CLK = 1'b0;
  logic       RST, BLK, nPL, S, XF, CLR_EN;
  logic [4:0] PAL;
  logic [8:0] PIX;
  logic       PIX_VALID, PIX_OPAQUE, PIX_BEHIND, WB_WE, UNDERRUN;

  fb_pixel_serializer_if bus();

  fb_pixel_serializer #(
    .FIFO_DEPTH(4),
    .TRANSP_NIB(4'h0),
    .BEHIND_NIB(4'h7)
  ) dut (
    .CLK(CLK), .RST(RST), .BLK(BLK), .nPL(nPL), .din_if(bus),
    .S(S), .XF(XF), .PAL(PAL), .CLR_EN(CLR_EN),
    .PIX(PIX), .PIX_VALID(PIX_VALID), .PIX_OPAQUE(PIX_OPAQUE),
    .PIX_BEHIND(PIX_BEHIND), .WB_WE(WB_WE), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, npl, blk, dv;
    logic [7:0] din;
    logic       s, xf;
    logic [4:0] pal;
    logic       clr;
    logic       e_rdy, e_val;
    logic [8:0] e_pix;
    logic       e_opq, e_beh, e_we, e_und;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic rst, logic npl, logic blk, logic dv, logic [7:0] din,
                              logic s, logic xf, logic [4:0] pal, logic clr,
                              logic e_rdy, logic e_val, logic [8:0] e_pix,
                              logic e_opq, logic e_beh, logic e_we, logic e_und);
    vec_t v;
    v.rst = rst; v.npl = npl; v.blk = blk; v.dv = dv; v.din = din;
    v.s = s; v.xf = xf; v.pal = pal; v.clr = clr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_pix = e_pix;
    v.e_opq = e_opq; v.e_beh = e_beh; v.e_we = e_we; v.e_und = e_und;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic idle_inputs();
    RST = 1'b0; nPL = 1'b1; BLK = 1'b0; S = 1'b0; XF = 1'b0;
    PAL = '0; CLR_EN = 1'b0; bus.DIN = '0; bus.DIN_VALID = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    RST = v.rst; nPL = v.npl; BLK = v.blk; bus.DIN_VALID = v.dv; bus.DIN = v.din;
    S = v.s; XF = v.xf; PAL = v.pal; CLR_EN = v.clr;
    tick();
    chk($sformatf("vec%0d.PIX", idx),        int'(PIX),           int'(v.e_pix));
    chk($sformatf("vec%0d.PIX_VALID", idx),  int'(PIX_VALID),     int'(v.e_val));
    chk($sformatf("vec%0d.PIX_OPAQUE", idx), int'(PIX_OPAQUE),    int'(v.e_opq));
    chk($sformatf("vec%0d.PIX_BEHIND", idx), int'(PIX_BEHIND),    int'(v.e_beh));
    chk($sformatf("vec%0d.WB_WE", idx),      int'(WB_WE),         int'(v.e_we));
    chk($sformatf("vec%0d.UNDERRUN", idx),   int'(UNDERRUN),      int'(v.e_und));
    chk($sformatf("vec%0d.DIN_READY", idx),  int'(bus.DIN_READY), int'(v.e_rdy));
  endtask

  initial begin
    logic [3:0] full_exp [9];
    logic [8:0] und_exp  [6];
    logic       we_exp   [8];
    int         we_cnt;

    idle_inputs();
    tick();

    // rst npl blk dv din s xf pal clr | rdy val pix opq beh we und
    // A: S=XF=0, PAL 13 -> A,7,3,0
    tbl.push_back(mk(1,1,0,0,8'h00,0,0,5'h00,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'hA7,0,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'h30,0,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0,5'h13,0, 1,1,9'h13A,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0,5'h13,0, 1,1,9'h137,1,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0,5'h13,0, 1,1,9'h133,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,0,0,5'h13,0, 1,1,9'h130,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    // B: S=1, XF=0 -> 7,A,0,3
    tbl.push_back(mk(0,0,0,0,8'h00,1,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'hA7,1,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'h30,1,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,0,5'h13,0, 1,1,9'h137,1,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,0,5'h13,0, 1,1,9'h13A,1,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,0,5'h13,0, 1,1,9'h130,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,0,5'h13,0, 1,1,9'h133,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,0,5'h13,0, 1,0,9'h000,0,0,0,0));
    // C: S=XF=1 -> A,7,3,0 with PAL 05 latched, live PAL 1F ignored, CLR_EN on
    tbl.push_back(mk(0,0,0,0,8'h00,1,1,5'h05,1, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'hA7,1,1,5'h1F,1, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,8'h30,1,1,5'h1F,1, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,1,5'h1F,1, 1,0,9'h000,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,1,5'h1F,1, 1,1,9'h05A,1,0,1,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,1,5'h1F,1, 1,1,9'h057,1,1,0,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,1,5'h1F,1, 1,1,9'h053,1,0,1,0));
    tbl.push_back(mk(0,1,1,0,8'h00,1,1,5'h1F,1, 1,1,9'h050,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,1,1,5'h1F,1, 1,0,9'h000,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // FIFO full: 5th push dropped, push during pop at full accepted
    full_exp = '{4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'h6, 4'h6};
    do_reset();
    nPL = 1'b0; tick(); nPL = 1'b1;
    bus.DIN_VALID = 1'b1;
    bus.DIN = 8'h11; tick();
    bus.DIN = 8'h22; tick();
    bus.DIN = 8'h33; tick();
    bus.DIN = 8'h44; tick();
    chk("full.ready_after4", int'(bus.DIN_READY), 0);
    bus.DIN = 8'h55; tick();
    chk("full.ready_after_drop", int'(bus.DIN_READY), 0);
    bus.DIN_VALID = 1'b0; BLK = 1'b1; tick();
    bus.DIN_VALID = 1'b1; bus.DIN = 8'h66; tick();
    chk("full.ready_pushpop", int'(bus.DIN_READY), 0);
    chk("full.first_pix", int'(PIX), 1);
    chk("full.first_valid", int'(PIX_VALID), 1);
    bus.DIN_VALID = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("full.pix%0d", i), int'(PIX), int'(full_exp[i]));
    end
    BLK = 1'b0; tick();
    chk("full.idle_valid", int'(PIX_VALID), 0);
    chk("full.no_underrun", int'(UNDERRUN), 0);

    // Underrun: two bytes, three pairs; flag sticky until reset
    und_exp = '{9'h1FC, 9'h1F5, 9'h1F9, 9'h1FE, 9'h000, 9'h000};
    do_reset();
    PAL = 5'h1F; nPL = 1'b0; tick(); nPL = 1'b1;
    BLK = 1'b1; bus.DIN_VALID = 1'b1;
    bus.DIN = 8'hC5; tick();
    bus.DIN = 8'h9E; tick();
    bus.DIN_VALID = 1'b0; tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("und.pix%0d", i), int'(PIX), int'(und_exp[i]));
      chk($sformatf("und.valid%0d", i), int'(PIX_VALID), 1);
      chk($sformatf("und.opaque%0d", i), int'(PIX_OPAQUE), (i < 4) ? 1 : 0);
      chk($sformatf("und.flag%0d", i), int'(UNDERRUN), (i < 4) ? 0 : 1);
    end
    BLK = 1'b0; tick();
    chk("und.idle_valid", int'(PIX_VALID), 0);
    nPL = 1'b0; tick(); nPL = 1'b1; tick(); tick();
    chk("und.sticky", int'(UNDERRUN), 1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("und.cleared", int'(UNDERRUN), 0);

    // Clear-after-scan: three pops then an underrun pair
    we_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    we_cnt = 0;
    do_reset();
    nPL = 1'b0; tick(); nPL = 1'b1;
    BLK = 1'b1; CLR_EN = 1'b1; bus.DIN_VALID = 1'b1;
    bus.DIN = 8'h12; tick();
    bus.DIN = 8'h34; tick();
    bus.DIN = 8'h56; tick();
    bus.DIN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (WB_WE) we_cnt++;
      chk($sformatf("clr.we%0d", i), int'(WB_WE), int'(we_exp[i]));
    end
    chk("clr.pulse_count", we_cnt, 3);
    BLK = 1'b0; CLR_EN = 1'b0; tick();

    // Preload flush mid-run, then reset mid-run
    do_reset();
    nPL = 1'b0; tick(); nPL = 1'b1;
    bus.DIN_VALID = 1'b1;
    bus.DIN = 8'h11; tick();
    bus.DIN = 8'h22; tick();
    bus.DIN = 8'h33; tick();
    bus.DIN = 8'h44; tick();
    bus.DIN_VALID = 1'b0; BLK = 1'b1; tick();
    tick();
    chk("npl.run_pix", int'(PIX), 9'h001);
    PAL = 5'h02; nPL = 1'b0; tick(); nPL = 1'b1; PAL = 5'h1F;
    chk("npl.flush_valid", int'(PIX_VALID), 0);
    chk("npl.flush_ready", int'(bus.DIN_READY), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("npl.prime_valid%0d", i), int'(PIX_VALID), 0);
    end
    bus.DIN_VALID = 1'b1;
    bus.DIN = 8'hA1; tick();
    chk("npl.one_byte_valid", int'(PIX_VALID), 0);
    bus.DIN = 8'hB2; tick();
    chk("npl.two_byte_valid", int'(PIX_VALID), 0);
    bus.DIN_VALID = 1'b0; tick();
    chk("npl.enter_run_valid", int'(PIX_VALID), 0);
    tick();
    chk("npl.new_pix", int'(PIX), 9'h02A);
    chk("npl.new_valid", int'(PIX_VALID), 1);
    RST = 1'b1; nPL = 1'b0; bus.DIN_VALID = 1'b1; tick(); RST = 1'b0; nPL = 1'b1;
    bus.DIN_VALID = 1'b0;
    chk("rst.pix", int'(PIX), 0);
    chk("rst.valid", int'(PIX_VALID), 0);
    chk("rst.opaque", int'(PIX_OPAQUE), 0);
    chk("rst.behind", int'(PIX_BEHIND), 0);
    chk("rst.we", int'(WB_WE), 0);
    chk("rst.underrun", int'(UNDERRUN), 0);
    chk("rst.ready", int'(bus.DIN_READY), 1);
    tick();
    chk("rst.stays_idle", int'(PIX_VALID), 0);
    tick();
    chk("rst.stays_idle2", int'(PIX_VALID), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
